// File: rtl/array_search_arbiter_if.sv
// Handshake bundle between the write/search requesters and the search arbiter.
// Master drives requests; slave is the array controller.
interface array_search_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 4
);
  logic             wr_valid;
  logic             wr_ready;
  logic [WIDTH-1:0] wr_data;
  logic             srch_valid;
  logic             srch_ready;
  logic [WIDTH-1:0] srch_key;
  logic             res_valid;
  logic             res_ready;
  logic             res_hit;
  logic [AW-1:0]    res_index;

  modport master (
    output wr_valid, wr_data,
    output srch_valid, srch_key,
    output res_ready,
    input  wr_ready, srch_ready,
    input  res_valid, res_hit, res_index
  );

  modport slave (
    input  wr_valid, wr_data,
    input  srch_valid, srch_key,
    input  res_ready,
    output wr_ready, srch_ready,
    output res_valid, res_hit, res_index
  );
endinterface

// File: rtl/array_search_arbiter.sv
// Register array shared between a round-robin write stream and a
// sequential membership search.
module array_search_arbiter #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  array_search_arbiter_if.slave bus,
  output logic [AW:0]           count,
  input  logic [AW-1:0]         rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    idx;
  logic [WIDTH-1:0] key;
  logic             last_grant;
  logic             res_hit;
  logic [AW-1:0]    res_index;
  logic             idle;
  logic             wr_fire;
  logic             srch_fire;
  logic             match;

  // last_grant = 1 means search won last; a tie then goes to write
  assign idle = !rst && (state == S_IDLE) && !clr;
  assign bus.wr_ready =
    idle && (!bus.srch_valid || last_grant);
  assign bus.srch_ready =
    idle && (!bus.wr_valid || !last_grant);
  assign wr_fire   = bus.wr_valid && bus.wr_ready;
  assign srch_fire = bus.srch_valid && bus.srch_ready;

  assign match = valid[idx] && (mem[idx] == key);

  assign bus.res_valid = (state == S_RESP);
  assign bus.res_hit   = res_hit;
  assign bus.res_index = res_index;
  assign rd_data       = mem[rd_addr];

  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr] <= bus.wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      valid      <= '0;
      wr_ptr     <= '0;
      idx        <= '0;
      count      <= '0;
      key        <= '0;
      last_grant <= 1'b1;
      res_hit    <= 1'b0;
      res_index  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          unique case (1'b1)
            clr: begin
              valid  <= '0;
              wr_ptr <= '0;
              count  <= '0;
            end
            wr_fire: begin
              valid[wr_ptr] <= 1'b1;
              wr_ptr        <= wr_ptr + 1'b1;
              last_grant    <= 1'b0;
              if (count != (AW+1)'(DEPTH))
                count <= count + 1'b1;
            end
            srch_fire: begin
              key        <= bus.srch_key;
              idx        <= '0;
              last_grant <= 1'b1;
              res_hit    <= 1'b0;
              res_index  <= '0;
              state <= (count == '0) ? S_RESP : S_SCAN;
            end
            default: ;
          endcase
        end
        S_SCAN: begin
          if (match) begin
            res_hit   <= 1'b1;
            res_index <= idx;
            state     <= S_RESP;
          end else if (idx == AW'(DEPTH - 1)) begin
            res_hit   <= 1'b0;
            res_index <= '0;
            state     <= S_RESP;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_RESP: begin
          if (bus.res_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_array_search_arbiter.sv
// Directed bench for array_search_arbiter.
// Expected values are hand-computed per test.
module tb_array_search_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr;
  logic [4:0] count;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  int checks = 0;
  int fails  = 0;

  array_search_arbiter_if #(.WIDTH(8), .AW(4)) bus ();

  array_search_arbiter #(.DEPTH(16), .WIDTH(8), .AW(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .bus     (bus),
    .count   (count),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic idle_inputs;
    clr            = 1'b0;
    bus.wr_valid   = 1'b0;
    bus.wr_data    = '0;
    bus.srch_valid = 1'b0;
    bus.srch_key   = '0;
    bus.res_ready  = 1'b0;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wr(input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    bus.wr_valid = 1'b1;
    bus.wr_data  = d;
    #1;
    while (!bus.wr_ready && n < 50) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 50) chk("wr_timeout", 1, 0);
    @(posedge clk);
    #1 bus.wr_valid = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a,
                    input logic [7:0] exp,
                    input string tag);
    @(negedge clk);
    rd_addr = a;
    #1 chk(tag, rd_data, exp);
  endtask

  task automatic srch(input logic [7:0] k,
                      input int hold,
                      output logic hit,
                      output logic [3:0] ix,
                      output int lat);
    int n = 0;
    @(negedge clk);
    bus.srch_valid = 1'b1;
    bus.srch_key   = k;
    #1;
    while (!bus.srch_ready && n < 50) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 50) chk("srch_timeout", 1, 0);
    @(posedge clk);
    #1 bus.srch_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.res_valid && lat < 40);
    if (!bus.res_valid) chk("res_timeout", 1, 0);
    hit = bus.res_hit;
    ix  = bus.res_index;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", bus.res_valid, 1);
      chk("hold_hit", bus.res_hit, hit);
      chk("hold_idx", bus.res_index, ix);
      chk("hold_rdy", {bus.wr_ready, bus.srch_ready}, 0);
    end
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1 bus.res_ready = 1'b0;
  endtask

  logic       hit;
  logic [3:0] ix;
  int         lat;
  logic [4:0] gv;
  logic       wf, sf, hs, busy;
  int         g, viol, n;

  initial begin
    rst = 1'b1;
    rd_addr = '0;
    idle_inputs();
    @(posedge clk);
    @(negedge clk);
    chk("rst_wr_ready", bus.wr_ready, 0);
    chk("rst_srch_ready", bus.srch_ready, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_res_hit", {bus.res_hit, bus.res_index}, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // fill with 20, clear, so stale 20s sit in entries 8-15
    for (int i = 0; i < 16; i++) wr(8'd20);
    chk("fill_count", count, 16);
    @(negedge clk);
    clr = 1'b1;
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'd99;
    #1;
    chk("clr_wr_ready", bus.wr_ready, 0);
    chk("clr_srch_ready", bus.srch_ready, 0);
    @(posedge clk);
    #1 clr = 1'b0;
    bus.wr_valid = 1'b0;
    @(negedge clk);
    chk("clr_count", count, 0);

    for (int i = 0; i < 8; i++) wr(8'(i * 6));
    @(negedge clk);
    chk("w8_count", count, 8);
    rd(4'd3, 8'd18, "rd3");
    srch(8'd18, 0, hit, ix, lat);
    chk("s18_hit", hit, 1);
    chk("s18_idx", ix, 3);
    chk("s18_lat", lat, 5);
    srch(8'd20, 0, hit, ix, lat);
    chk("s20_hit", hit, 0);
    chk("s20_idx", ix, 0);
    chk("s20_lat", lat, 17);

    // both requesters held high from reset
    @(negedge clk);
    rst = 1'b1;
    bus.wr_valid   = 1'b1;
    bus.wr_data    = 8'd1;
    bus.srch_valid = 1'b1;
    bus.srch_key   = 8'd1;
    bus.res_ready  = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    g = 0; gv = '0; busy = 1'b0; viol = 0; n = 0;
    while (g < 5 && n < 100) begin
      @(negedge clk);
      n++;
      wf = bus.wr_valid && bus.wr_ready;
      sf = bus.srch_valid && bus.srch_ready;
      hs = bus.res_valid && bus.res_ready;
      if (busy && bus.wr_ready) viol++;
      if (wf || sf) begin
        gv = {gv[3:0], wf};
        g++;
      end
      if (sf) busy = 1'b1;
      @(posedge clk);
      #1;
      if (hs) busy = 1'b0;
      if (wf) bus.wr_data = bus.wr_data + 8'd1;
    end
    bus.wr_valid   = 1'b0;
    bus.srch_valid = 1'b0;
    bus.res_ready  = 1'b0;
    chk("arb_grants", gv, 5'b10101);
    chk("arb_busy_wr", viol, 0);
    @(negedge clk);
    chk("arb_count", count, 3);
    rd(4'd0, 8'd1, "arb_rd0");
    rd(4'd1, 8'd2, "arb_rd1");
    rd(4'd2, 8'd3, "arb_rd2");

    // wrap: 17 writes overwrite entry 0
    do_reset();
    for (int i = 1; i <= 17; i++) wr(8'(i));
    @(negedge clk);
    chk("wrap_count", count, 16);
    rd(4'd0, 8'd17, "wrap_rd0");
    rd(4'd1, 8'd2, "wrap_rd1");
    srch(8'd1, 0, hit, ix, lat);
    chk("wrap_s1_hit", hit, 0);
    chk("wrap_s1_lat", lat, 17);
    srch(8'd17, 0, hit, ix, lat);
    chk("wrap_s17_hit", hit, 1);
    chk("wrap_s17_idx", ix, 0);
    chk("wrap_s17_lat", lat, 2);

    // empty search with held result
    do_reset();
    srch(8'd5, 5, hit, ix, lat);
    chk("empty_hit", hit, 0);
    chk("empty_lat", lat, 1);
    @(negedge clk);
    chk("post_hs_ready", bus.srch_ready, 1);
    chk("post_hs_valid", bus.res_valid, 0);

    // reset mid-scan
    wr(8'd5);
    wr(8'd6);
    @(negedge clk);
    bus.srch_valid = 1'b1;
    bus.srch_key   = 8'd99;
    @(posedge clk);
    #1 bus.srch_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("scan_no_res", bus.res_valid, 0);
    chk("scan_wr_ready", bus.wr_ready, 0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rstscan_valid", bus.res_valid, 0);
    chk("rstscan_count", count, 0);
    chk("rstscan_idle", bus.srch_ready, 1);
    repeat (20) @(negedge clk);
    chk("rstscan_nores", bus.res_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
